// File: rtl/gcd_sub_ctrl.sv
// Controller for a subtract-based Euclid GCD unit driving an external combinational subtractor.
// Optional iteration counter output resp_iters is enabled by defining GCD_ITER_COUNT_EN.
module gcd_sub_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] sub_a,
   output logic [WIDTH-1:0] sub_b,
   input  logic [WIDTH-1:0] sub_diff,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_gcd
`ifdef GCD_ITER_COUNT_EN
   ,
   output logic [CNT_W-1:0] resp_iters
`endif
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] gcd_q, gcd_d;
   logic             accept;

   // The external subtractor is fixed at 32 bits.
   if (WIDTH != 32 || CNT_W < 1) begin : g_cfg_check
      $error("gcd_sub_ctrl: WIDTH must be 32 and CNT_W at least 1");
   end

   assign accept     = (state_q == IDLE) && req_valid;
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == DONE);
   assign sub_a      = a_q;
   assign sub_b      = b_q;
   assign resp_gcd   = gcd_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         gcd_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gcd_q   <= gcd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      gcd_d   = gcd_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d     = req_a;
               b_d     = req_b;
               state_d = CALC;
            end
         end
         CALC: begin
            // One Euclid step per cycle; the A>=B branch takes the external difference.
            if (b_q == '0) begin
               gcd_d   = a_q;
               state_d = DONE;
            end else if (a_q < b_q) begin
               a_d = b_q;
               b_d = a_q;
            end else begin
               a_d = sub_diff;
            end
         end
         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef GCD_ITER_COUNT_EN
   logic [CNT_W-1:0] iters_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         iters_q <= '0;
      end else if (accept) begin
         iters_q <= '0;
      end else if (state_q == CALC) begin
         iters_q <= sat_inc(iters_q);
      end
   end

   assign resp_iters = iters_q;
`endif

endmodule

// File: tb/tb_gcd_sub_ctrl.sv
// Self-checking bench for gcd_sub_ctrl with a behavioural subtractor and Euclid reference model.
module tb_gcd_sub_ctrl;
   localparam int WIDTH = 32;
   localparam int CNT_W = 32;
   localparam int LIMIT = 6000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [WIDTH-1:0] req_a = '0;
   logic [WIDTH-1:0] req_b = '0;
   logic [WIDTH-1:0] sub_a, sub_b, sub_diff;
   logic             resp_valid;
   logic             resp_ready = 1'b1;
   logic [WIDTH-1:0] resp_gcd;
`ifdef GCD_ITER_COUNT_EN
   logic [CNT_W-1:0] resp_iters;
   logic [CNT_W-1:0] got_iters;
`endif

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
   logic [WIDTH-1:0] got_gcd;
   int               got_n;

   logic [WIDTH-1:0] za[4] = '{32'd0, 32'd7, 32'd0, 32'd1};
   logic [WIDTH-1:0] zb[4] = '{32'd0, 32'd0, 32'd7, 32'd1};
   logic [WIDTH-1:0] zg[4] = '{32'd0, 32'd7, 32'd7, 32'd1};
   int               zn[4] = '{1, 1, 2, 3};

   gcd_sub_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .sub_a      (sub_a),
      .sub_b      (sub_b),
      .sub_diff   (sub_diff),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_gcd   (resp_gcd)
`ifdef GCD_ITER_COUNT_EN
      ,
      .resp_iters (resp_iters)
`endif
   );

   // External 32-bit combinational subtractor, no carry-out.
   assign sub_diff = sub_a - sub_b;

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Expected operand pair seen on the subtractor buses for every CALC cycle.
   function automatic void build_expect(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0);
      logic [WIDTH-1:0] a, b, t;
      a = a0;
      b = b0;
      exp_a.delete();
      exp_b.delete();
      while (exp_a.size() < LIMIT) begin
         exp_a.push_back(a);
         exp_b.push_back(b);
         if (b == 0) break;
         if (a < b) begin
            t = a;
            a = b;
            b = t;
         end else begin
            a = a - b;
         end
      end
   endfunction

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      @(negedge clk);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Starts at the negedge of the first CALC cycle, returns at the first DONE negedge.
   task automatic collect();
      int n;
      n = 0;
      got_a.delete();
      got_b.delete();
      while (resp_valid !== 1'b1 && n < LIMIT) begin
         got_a.push_back(sub_a);
         got_b.push_back(sub_b);
         n++;
         @(negedge clk);
      end
      got_n = n;
      if (resp_valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL collect_timeout resp_valid=%b after %0d cycles, required 1", resp_valid, n);
      end
      got_gcd = resp_gcd;
`ifdef GCD_ITER_COUNT_EN
      got_iters = resp_iters;
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b need=1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b need=0", resp_valid); end
      checks++; if (resp_gcd !== 32'd0) begin errors++; $display("FAIL reset_resp_gcd got=%h need=0", resp_gcd); end
      checks++; if (sub_a !== 32'd0 || sub_b !== 32'd0) begin errors++; $display("FAIL reset_sub got=%h,%h need=0,0", sub_a, sub_b); end
`ifdef GCD_ITER_COUNT_EN
      checks++; if (resp_iters !== '0) begin errors++; $display("FAIL reset_iters got=%0d need=0", resp_iters); end
`endif
   endtask

   task automatic test_trace();
      resp_ready = 1'b1;
      build_expect(32'd12, 32'd8);
      issue(32'd12, 32'd8);
      collect();
      checks++; if (got_gcd !== 32'd4) begin errors++; $display("FAIL trace_gcd got=%0d need=4", got_gcd); end
      checks++; if (got_n != 6 || exp_a.size() != 6) begin errors++; $display("FAIL trace_latency got=%0d need=6 (model %0d)", got_n, exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         checks++;
         if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL trace_sub[%0d] got=(%0d,%0d) need=(%0d,%0d)", i, got_a[i], got_b[i], exp_a[i], exp_b[i]);
         end
      end
      checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL trace_done_flags got valid=%b ready=%b need 1,0", resp_valid, req_ready); end
`ifdef GCD_ITER_COUNT_EN
      checks++; if (got_iters !== 6) begin errors++; $display("FAIL trace_iters got=%0d need=6", got_iters); end
`endif
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL trace_release got valid=%b ready=%b need 0,1", resp_valid, req_ready); end
   endtask

   task automatic test_zero_cases();
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(za[i], zb[i]);
         collect();
         checks++;
         if (got_gcd !== zg[i]) begin errors++; $display("FAIL zero_gcd(%0d,%0d) got=%0d need=%0d", za[i], zb[i], got_gcd, zg[i]); end
         checks++;
         if (got_n != zn[i]) begin errors++; $display("FAIL zero_latency(%0d,%0d) got=%0d need=%0d", za[i], zb[i], got_n, zn[i]); end
      end
   endtask

   task automatic test_full_width();
      logic [WIDTH-1:0] pa[3] = '{32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [WIDTH-1:0] pb[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h5555_5555};
      resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         build_expect(pa[i], pb[i]);
         issue(pa[i], pb[i]);
         collect();
         checks++;
         if (got_gcd !== ref_gcd(pa[i], pb[i])) begin errors++; $display("FAIL wide_gcd(%h,%h) got=%h need=%h", pa[i], pb[i], got_gcd, ref_gcd(pa[i], pb[i])); end
         checks++;
         if (got_n != exp_a.size()) begin errors++; $display("FAIL wide_latency(%h,%h) got=%0d need=%0d", pa[i], pb[i], got_n, exp_a.size()); end
      end
      // The (FFFFFFFF,FFFFFFFE) run takes billions of steps, so only its opening steps are checked, then aborted.
      build_expect(32'hFFFF_FFFF, 32'hFFFF_FFFE);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFE);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (sub_a !== exp_a[i] || sub_b !== exp_b[i]) begin
            errors++;
            $display("FAIL wide_prefix[%0d] got=(%h,%h) need=(%h,%h)", i, sub_a, sub_b, exp_a[i], exp_b[i]);
         end
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL wide_abort got valid=%b ready=%b need 0,1", resp_valid, req_ready); end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] g;
      g = ref_gcd(32'd36, 32'd24);
      resp_ready = 1'b0;
      issue(32'd36, 32'd24);
      collect();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (resp_valid !== 1'b1 || resp_gcd !== g || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d] got valid=%b gcd=%0d ready=%b need 1,%0d,0", i, resp_valid, resp_gcd, req_ready, g);
         end
         req_valid = (i == 1);
         req_a     = 32'd5;
         req_b     = 32'd3;
         @(negedge clk);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got valid=%b ready=%b need 0,1", resp_valid, req_ready); end
      checks++; if (sub_a !== g || sub_b !== 32'd0) begin errors++; $display("FAIL bp_ignored_req got sub=(%0d,%0d) need (%0d,0)", sub_a, sub_b, g); end
   endtask

   task automatic test_reset_mid();
      resp_ready = 1'b1;
      issue(32'd48, 32'd18);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_flags got ready=%b valid=%b need 1,0", req_ready, resp_valid); end
      checks++; if (resp_gcd !== 32'd0 || sub_a !== 32'd0 || sub_b !== 32'd0) begin errors++; $display("FAIL midrst_regs got gcd=%0d sub=(%0d,%0d) need 0,(0,0)", resp_gcd, sub_a, sub_b); end
      build_expect(32'd48, 32'd18);
      issue(32'd48, 32'd18);
      collect();
      checks++; if (got_gcd !== 32'd6) begin errors++; $display("FAIL midrst_gcd got=%0d need=6", got_gcd); end
      checks++; if (got_n != exp_a.size()) begin errors++; $display("FAIL midrst_latency got=%0d need=%0d", got_n, exp_a.size()); end
`ifdef GCD_ITER_COUNT_EN
      checks++; if (got_iters !== CNT_W'(exp_a.size())) begin errors++; $display("FAIL midrst_iters got=%0d need=%0d", got_iters, exp_a.size()); end
`endif
   endtask

   task automatic test_back_to_back();
      resp_ready = 1'b1;
      issue(32'd100, 32'd75);
      collect();
      checks++; if (got_gcd !== 32'd25) begin errors++; $display("FAIL b2b_first_gcd got=%0d need=25", got_gcd); end
      req_valid = 1'b1;
      req_a     = 32'd21;
      req_b     = 32'd14;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_return got=%b need=1", req_ready); end
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (sub_a !== 32'd21 || sub_b !== 32'd14) begin errors++; $display("FAIL b2b_load got=(%0d,%0d) need=(21,14)", sub_a, sub_b); end
      build_expect(32'd21, 32'd14);
      collect();
      checks++; if (got_gcd !== 32'd7) begin errors++; $display("FAIL b2b_gcd got=%0d need=7", got_gcd); end
      checks++; if (got_n != exp_a.size()) begin errors++; $display("FAIL b2b_latency got=%0d need=%0d", got_n, exp_a.size()); end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b, g;
      resp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i < 10) begin
            a = $urandom_range(0, 300);
            b = $urandom_range(0, 300);
         end else begin
            g = $urandom_range(1, 1 << 25);
            a = g * $urandom_range(0, 40);
            b = g * $urandom_range(0, 40);
         end
         build_expect(a, b);
         issue(a, b);
         collect();
         checks++;
         if (got_gcd !== ref_gcd(a, b)) begin errors++; $display("FAIL rand_gcd(%0d,%0d) got=%0d need=%0d", a, b, got_gcd, ref_gcd(a, b)); end
         checks++;
         if (got_n != exp_a.size()) begin errors++; $display("FAIL rand_latency(%0d,%0d) got=%0d need=%0d", a, b, got_n, exp_a.size()); end
`ifdef GCD_ITER_COUNT_EN
         checks++;
         if (got_iters !== CNT_W'(exp_a.size())) begin errors++; $display("FAIL rand_iters(%0d,%0d) got=%0d need=%0d", a, b, got_iters, exp_a.size()); end
`endif
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_trace();
      test_zero_cases();
      test_full_width();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
